seq_detector_prog: RTL and testbench
====================================

Name: seq_detector_prog

Overview:
- Programmable serial bit-pattern detector: a runtime-loaded pattern of up to MAX_LEN bits, matched against a serial input stream.
- Moore-style registered match output, with the overlapping/non-overlapping mode selected at runtime.
- Saturating match counter for status/debug.
- Generalises the fixed-pattern 1010 detectors; sits after a serial receiver/deserialiser front end.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, 4, width of pat_len; must hold MAX_LEN.
- CNT_W, 8, width of match counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_load  in  1  latch pattern, pat_len and overlap this cycle.
- pattern  in  MAX_LEN  target pattern; pattern[pat_len-1] is the first bit received, pattern[0] the last.
- pat_len  in  LEN_W  pattern length, legal range 1..MAX_LEN.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- x_valid  in  1  qualifies x this cycle.
- x  in  1  serial data bit.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  match pulse, registered (Moore).
- match_cnt  out  CNT_W  matches since reset/clear, saturating.
- cfg_err  out  1  latched configuration is illegal; detector disabled.

Behaviour:
- Reset (async, rst=1):
  - Outputs: z=0, match_cnt=0, cfg_err=1.
  - Internal state: history=0, fill=0.
  - Config registers: pattern_q=0, len_q=0, overlap_q=0. The detector stays disabled until the first legal cfg_load.
- Configuration:
  - On a clk edge with cfg_load=1: pattern_q, len_q and overlap_q are loaded; history and fill are cleared; z goes to 0.
  - x on that same cycle is ignored.
  - cfg_err <= 1 if pat_len==0 or pat_len>MAX_LEN, else 0.
- Datapath:
  - History: a MAX_LEN-bit shift register. On each edge with x_valid=1 (and cfg_load=0) it updates as history <= {history[MAX_LEN-2:0], x}.
  - Fill: a counter of valid bits since the last clear, saturating at len_q.
  - Hit: hit = x_valid & ~cfg_err & (fill_next >= len_q) & (history_next[len_q-1:0] == pattern_q[len_q-1:0]).
    - fill_next and history_next are the values after shifting in the current bit.
    - The compare masks bits at or above len_q.
- Output timing:
  - z <= hit. z is high for exactly one cycle, the cycle after the edge that sampled the final pattern bit.
  - z is 0 on any cycle whose preceding edge had no hit, including cycles where x_valid=0.
- Mode:
  - overlap_q=1: history and fill are kept after a hit, so suffix bits are reused.
  - overlap_q=0: on a hit edge, fill <= 0. The next match needs len_q fresh bits. History may retain its contents; fill gates reuse.
- Counter:
  - match_cnt increments on each hit edge and saturates at 2^CNT_W-1.
  - cnt_clr=1 sets match_cnt to 0. cnt_clr wins over a simultaneous hit (that hit is not counted; z still pulses).
- Boundary cases:
  - pat_len==1: every valid bit equal to pattern_q[0] hits. In non-overlapping mode this is identical to overlapping mode.
  - pat_len==MAX_LEN: the full register is compared.
  - Idle cycles (x_valid=0) do not advance history or fill.
  - cfg_load during a stream discards the partial history; no hit is possible on the load edge.
  - rst asserted mid-stream: immediate return to reset values regardless of clk.
- Structure:
  - No combinational path from inputs to z; z is registered.
  - match_cnt and cfg_err are registered.

Test Plan:
- Reset: rst pulse -> z=0, match_cnt=0, cfg_err=1; input stream 1010 with no prior cfg_load -> no z pulses.
- Non-overlap 1010: cfg_load pattern=8'b00001010, pat_len=4, overlap=0; stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0 (one bit per cycle) -> z pulses after the 5th and 13th bits; match_cnt=2.
- Overlap 1010: same stream, overlap=1 -> z after bits 5, 7, 13 and 15; match_cnt=4.
- Gaps and length edges:
  - 1010 stream with x_valid=0 cycles interleaved -> same matches as the gap-free case, just delayed.
  - pat_len=8, pattern=8'hA5 -> hit only after all 8 bits.
  - pat_len=1, pattern[0]=1 -> z for every valid 1.
- Illegal/abort:
  - pat_len=0 or 9 -> cfg_err=1, no hits.
  - cfg_load after 101 of 1010, then bit 0 -> no hit.
  - rst mid-sequence -> all outputs cleared.
- Counter:
  - CNT_W=2 with 5 matches -> match_cnt holds at 3.
  - cnt_clr on a hit edge -> match_cnt=0 and z=1.

Source files
------------

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: runtime-loaded pattern of up to
// MAX_LEN bits, registered match pulse, overlap mode select, saturating match counter.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               overlap_q;
  logic [MAX_LEN-1:0] history;
  logic [LEN_W-1:0]   fill;

  logic [MAX_LEN-1:0] history_next;
  logic [LEN_W-1:0]   fill_next;
  logic [MAX_LEN-1:0] mask;
  logic               hit;
  logic               len_bad;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    history_next = {history[MAX_LEN-2:0], x};
    fill_next    = (fill >= len_q) ? len_q : fill + LEN_W'(1);
    mask         = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
    // Only the low len_q bits of the window take part in the compare.
    hit = x_valid & ~cfg_load & ~cfg_err & (fill_next >= len_q) &
          (((history_next ^ pattern_q) & mask) == '0);
    len_bad = (pat_len == '0) || (pat_len > LEN_W'(MAX_LEN));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_q <= '0;
      len_q     <= '0;
      overlap_q <= 1'b0;
      history   <= '0;
      fill      <= '0;
      z         <= 1'b0;
      cfg_err   <= 1'b1;
    end else if (cfg_load) begin
      pattern_q <= pattern;
      len_q     <= pat_len;
      overlap_q <= overlap;
      history   <= '0;
      fill      <= '0;
      z         <= 1'b0;
      cfg_err   <= len_bad;
    end else begin
      z <= hit;
      if (x_valid) begin
        history <= history_next;
        // Non-overlapping mode forces a full set of fresh bits before the next hit.
        fill    <= (hit && !overlap_q) ? '0 : fill_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed, table-driven bench for seq_detector_prog; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_seq_detector_prog;

  typedef struct {
    logic       load;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ov;
    logic       vld;
    logic       xb;
    logic       clr;
    logic       ez;
    logic [7:0] ecnt;
    logic       eerr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_load = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] pat_len = '0;
  logic       overlap = 1'b0;
  logic       x_valid = 1'b0;
  logic       x = 1'b0;
  logic       cnt_clr = 1'b0;
  logic       z, cfg_err, z2, cfg_err2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  seq_detector_prog dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .x_valid(x_valid), .x(x), .cnt_clr(cnt_clr),
    .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detector_prog #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .pat_len(pat_len),
    .overlap(overlap), .x_valid(x_valid), .x(x), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t ld(input logic [7:0] p, input logic [3:0] l, input logic ov,
                              input logic clr, input logic vld, input logic xb,
                              input logic [7:0] ec, input logic ee);
    vec_t v;
    v.load = 1'b1; v.pat = p; v.len = l; v.ov = ov; v.vld = vld; v.xb = xb;
    v.clr = clr; v.ez = 1'b0; v.ecnt = ec; v.eerr = ee;
    return v;
  endfunction

  function automatic vec_t bt(input logic vld, input logic xb, input logic clr,
                              input logic ez, input logic [7:0] ec, input logic ee);
    vec_t v;
    v.load = 1'b0; v.pat = '0; v.len = '0; v.ov = 1'b0; v.vld = vld; v.xb = xb;
    v.clr = clr; v.ez = ez; v.ecnt = ec; v.eerr = ee;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    cfg_load = v.load; pattern = v.pat; pat_len = v.len; overlap = v.ov;
    x_valid = v.vld; x = v.xb; cnt_clr = v.clr;
    @(posedge clk);
    #1;
    check({tag, " z"}, 32'(z), 32'(v.ez));
    check({tag, " match_cnt"}, 32'(match_cnt), 32'(v.ecnt));
    check({tag, " cfg_err"}, 32'(cfg_err), 32'(v.eerr));
    check({tag, " z(cnt2)"}, 32'(z2), 32'(v.ez));
    check({tag, " cfg_err(cnt2)"}, 32'(cfg_err2), 32'(v.eerr));
  endtask

  initial begin
    // Non-overlapping 1010 on stream 1,1,0,1,0,1,0,1,1,1,0,1,0,1,0
    vecs.push_back(ld(8'h0A, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 1,8'd1,0)); vecs.push_back(bt(1,1,0, 0,8'd1,0));
    vecs.push_back(bt(1,0,0, 0,8'd1,0)); vecs.push_back(bt(1,1,0, 0,8'd1,0));
    vecs.push_back(bt(1,1,0, 0,8'd1,0)); vecs.push_back(bt(1,1,0, 0,8'd1,0));
    vecs.push_back(bt(1,0,0, 0,8'd1,0)); vecs.push_back(bt(1,1,0, 0,8'd1,0));
    vecs.push_back(bt(1,0,0, 1,8'd2,0)); vecs.push_back(bt(1,1,0, 0,8'd2,0));
    vecs.push_back(bt(1,0,0, 0,8'd2,0));
    // Overlapping 1010, same stream
    vecs.push_back(ld(8'h0A, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 1,8'd1,0)); vecs.push_back(bt(1,1,0, 0,8'd1,0));
    vecs.push_back(bt(1,0,0, 1,8'd2,0)); vecs.push_back(bt(1,1,0, 0,8'd2,0));
    vecs.push_back(bt(1,1,0, 0,8'd2,0)); vecs.push_back(bt(1,1,0, 0,8'd2,0));
    vecs.push_back(bt(1,0,0, 0,8'd2,0)); vecs.push_back(bt(1,1,0, 0,8'd2,0));
    vecs.push_back(bt(1,0,0, 1,8'd3,0)); vecs.push_back(bt(1,1,0, 0,8'd3,0));
    vecs.push_back(bt(1,0,0, 1,8'd4,0));
    // 1010 with idle cycles interleaved (an idle x=1 must not shift in)
    vecs.push_back(ld(8'h0A, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(0,0,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0)); vecs.push_back(bt(0,0,0, 0,8'd0,0));
    vecs.push_back(bt(0,1,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 1,8'd1,0)); vecs.push_back(bt(0,0,0, 0,8'd1,0));
    // Full-length pattern A5 = 1,0,1,0,0,1,0,1
    vecs.push_back(ld(8'hA5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(1,0,0, 0,8'd0,0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(1,0,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0)); vecs.push_back(bt(1,1,0, 1,8'd1,0));
    vecs.push_back(bt(1,0,0, 0,8'd1,0));
    // Illegal lengths 0 and 9
    vecs.push_back(ld(8'h0A, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1));
    vecs.push_back(bt(1,1,0, 0,8'd0,1)); vecs.push_back(bt(1,0,0, 0,8'd0,1));
    vecs.push_back(bt(1,1,0, 0,8'd0,1)); vecs.push_back(bt(1,0,0, 0,8'd0,1));
    vecs.push_back(ld(8'h0A, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1));
    vecs.push_back(bt(1,1,0, 0,8'd0,1)); vecs.push_back(bt(1,0,0, 0,8'd0,1));
    vecs.push_back(bt(1,1,0, 0,8'd0,1)); vecs.push_back(bt(1,0,0, 0,8'd0,1));
    // Reload after 101: the 0 on the load edge and the next 0 give no hit
    vecs.push_back(ld(8'h0A, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0)); vecs.push_back(bt(1,0,0, 0,8'd0,0));
    vecs.push_back(bt(1,1,0, 0,8'd0,0));
    vecs.push_back(ld(8'h0A, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0));
    vecs.push_back(bt(1,0,0, 0,8'd0,0));

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset z", 32'(z), 32'd0);
    check("reset match_cnt", 32'(match_cnt), 32'd0);
    check("reset cfg_err", 32'(cfg_err), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(bt(1,1,0, 0,8'd0,1), "nocfg b1");
    run_vec(bt(1,0,0, 0,8'd0,1), "nocfg b2");
    run_vec(bt(1,1,0, 0,8'd0,1), "nocfg b3");
    run_vec(bt(1,0,0, 0,8'd0,1), "nocfg b4");

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Length 1, pattern 8'h01 (upper bits masked): five hits, 2-bit counter pins at 3
    run_vec(ld(8'h01, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "len1 load");
    run_vec(bt(1,1,0, 1,8'd1,0), "len1 b1");
    run_vec(bt(1,1,0, 1,8'd2,0), "len1 b2");
    run_vec(bt(1,0,0, 0,8'd2,0), "len1 b3");
    run_vec(bt(1,1,0, 1,8'd3,0), "len1 b4");
    check("sat cnt2 after 3", 32'(match_cnt2), 32'd3);
    run_vec(bt(1,1,0, 1,8'd4,0), "len1 b5");
    run_vec(bt(1,1,0, 1,8'd5,0), "len1 b6");
    check("sat cnt2 after 5", 32'(match_cnt2), 32'd3);

    // cnt_clr coinciding with an overlapping hit
    run_vec(ld(8'h0A, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "clr load");
    run_vec(bt(1,1,0, 0,8'd0,0), "clr b1");
    run_vec(bt(1,0,0, 0,8'd0,0), "clr b2");
    run_vec(bt(1,1,0, 0,8'd0,0), "clr b3");
    run_vec(bt(1,0,0, 1,8'd1,0), "clr b4");
    run_vec(bt(1,1,0, 0,8'd1,0), "clr b5");
    run_vec(bt(1,0,1, 1,8'd0,0), "clr b6 hit+clr");
    check("clr cnt2", 32'(match_cnt2), 32'd0);
    run_vec(bt(1,1,0, 0,8'd0,0), "clr b7");
    run_vec(bt(1,0,0, 1,8'd1,0), "clr b8");

    // Asynchronous reset mid-stream, between clock edges
    run_vec(ld(8'h0A, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0), "arst load");
    run_vec(bt(1,1,0, 0,8'd0,0), "arst b1");
    run_vec(bt(1,0,0, 0,8'd0,0), "arst b2");
    run_vec(bt(1,1,0, 0,8'd0,0), "arst b3");
    run_vec(bt(1,0,0, 1,8'd1,0), "arst b4");
    #2 rst = 1'b1;
    #1;
    check("arst z", 32'(z), 32'd0);
    check("arst match_cnt", 32'(match_cnt), 32'd0);
    check("arst cfg_err", 32'(cfg_err), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    run_vec(bt(1,1,0, 0,8'd0,1), "post b1");
    run_vec(bt(1,0,0, 0,8'd0,1), "post b2");
    run_vec(bt(1,1,0, 0,8'd0,1), "post b3");
    run_vec(bt(1,0,0, 0,8'd0,1), "post b4");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
